// File: rtl/sr_bank_arbiter.sv
// Two-requester command arbiter for a bank of N SR flip-flops: IDLE -> ISSUE -> SETTLE.
// All outputs are registered; shadow tracks the bank's q values.
module sr_bank_arbiter #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          op_a,
  input  logic [IW-1:0] idx_a,
  input  logic          req_b,
  input  logic          op_b,
  input  logic [IW-1:0] idx_b,
  input  logic          clr_all,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic [N-1:0]  s,
  output logic [N-1:0]  r,
  output logic [N-1:0]  shadow,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_ptr_b;
  logic          r_win_b;
  logic          r_win_clr;
  logic          r_op;
  logic [IW-1:0] r_idx;

  logic          w_pick_b;
  logic          w_op;
  logic [IW-1:0] w_idx;
  logic          w_in_range;
  logic [N-1:0]  w_dec;
  logic [N-1:0]  w_shadow_next;

  // B wins only when A is absent or the pointer says it is B's turn.
  assign w_pick_b   = req_b && (!req_a || r_ptr_b);
  assign w_op       = w_pick_b ? op_b : op_a;
  assign w_idx      = w_pick_b ? idx_b : idx_a;
  assign w_in_range = (32'(w_idx) < N);

  // An out-of-range index decodes to all zeros, so it drives nothing and leaves shadow alone.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign w_dec[gi]         = (w_idx == IW'(gi));
      assign w_shadow_next[gi] = (r_idx == IW'(gi)) ? r_op : shadow[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr_b   <= 1'b0;
      r_win_b   <= 1'b0;
      r_win_clr <= 1'b0;
      r_op      <= 1'b0;
      r_idx     <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      s         <= '0;
      r         <= '0;
      shadow    <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_all) begin
            r_state   <= ISSUE;
            busy      <= 1'b1;
            r_win_clr <= 1'b1;
            s         <= '0;
            r         <= '1;
          end else if (req_a || req_b) begin
            r_state   <= ISSUE;
            busy      <= 1'b1;
            r_win_clr <= 1'b0;
            r_win_b   <= w_pick_b;
            r_op      <= w_op;
            r_idx     <= w_idx;
            gnt_a     <= !w_pick_b;
            gnt_b     <= w_pick_b;
            s         <= w_op ? w_dec : '0;
            r         <= w_op ? '0 : w_dec;
            err       <= !w_in_range;
          end
        end
        ISSUE: begin
          r_state <= SETTLE;
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
          s       <= '0;
          r       <= '0;
          err     <= 1'b0;
          if (r_win_clr) begin
            shadow <= '0;
          end else begin
            shadow  <= w_shadow_next;
            r_ptr_b <= !r_win_b;
          end
        end
        SETTLE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sr_bank_arbiter.md
SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

Interface
REQ-001 Parameter: N, 8, number of SR flip-flops in the controlled bank (1..16).
REQ-002 Parameter: IW, 3, index width; SHALL satisfy 2**IW >= N.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 Port: req_a  input  1  requester A command request; held high until gnt_a.
REQ-006 Port: op_a  input  1  requester A operation: 1 = set, 0 = clear.
REQ-007 Port: idx_a  input  IW  requester A target bit index.
REQ-008 Port: req_b, op_b, idx_b  input  1/1/IW  requester B, same meaning as A.
REQ-009 Port: clr_all  input  1  request to clear every bank bit.
REQ-010 Port: gnt_a, gnt_b  output  1 each  one-cycle grant pulse per accepted command.
REQ-011 Port: s  output  N  per-bit set drive to the bank.
REQ-012 Port: r  output  N  per-bit reset drive to the bank.
REQ-013 Port: shadow  output  N  controller's model of bank q values.
REQ-014 Port: busy  output  1  high whenever FSM is not IDLE.
REQ-015 Port: err  output  1  one-cycle pulse when a granted idx >= N.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 FSM SHALL have states IDLE, ISSUE, SETTLE.
REQ-018 IDLE: if clr_all, or req_a or req_b high at an edge, SHALL latch winner, op, idx and go to ISSUE; else stay.
REQ-019 Priority: clr_all over requesters; between A and B, round-robin, the requester not granted last wins; pointer favours A after reset.
REQ-020 clr_all winner: in ISSUE, r = all ones, s = 0, no gnt; shadow becomes 0 at end of ISSUE.
REQ-021 Requester winner: in ISSUE, gnt of winner = 1 for exactly that cycle; s[idx] = 1 if op=1 else r[idx] = 1; all other bits 0.
REQ-022 shadow[idx] SHALL update to op at end of ISSUE; round-robin pointer updates at the same edge.
REQ-023 idx >= N: grant still issued, s = r = 0, shadow unchanged, err = 1 during ISSUE.
REQ-024 ISSUE SHALL always last exactly one cycle, then go to SETTLE.
REQ-025 SETTLE: s = r = 0, no gnt; next edge returns to IDLE; throughput one command per 3 cycles.
REQ-026 Request latency: req sampled high in IDLE at edge t gives grant and drive during cycle t..t+1, i.e. one cycle after sampling.
REQ-027 s[i] and r[i] SHALL never both be 1 in any cycle, for any i.
REQ-028 Requests arriving while busy SHALL be held off; a req dropped before its grant is withdrawn without effect.
REQ-029 Redundant ops (set of a bit already 1) SHALL still be issued and granted normally.
REQ-030 Simultaneous A and B on the same idx with opposite ops: the round-robin winner executes first; the loser executes in a later cycle if still requesting.

Reset
REQ-031 rst = 0 at an edge SHALL force IDLE, s = 0, r = 0, gnt_a = gnt_b = 0, busy = 0, err = 0, shadow = 0, pointer = A, overriding any state including mid-ISSUE.
REQ-032 After rst returns high, the first command SHALL be accepted at the next edge with req high.

Verification
REQ-033 Reset then req_a=1, op_a=1, idx_a=3 -> one cycle later gnt_a=1, s=8'h08, r=0; shadow=8'h08 after; busy high 2 cycles.
REQ-034 req_a and req_b both high (A: set 1, B: set 2), held -> A granted first (s=8'h02), B granted 3 cycles later (s=8'h04); shadow=8'h06.
REQ-035 clr_all=1 with req_b pending, shadow=8'h06 -> r=8'hFF one cycle, shadow=8'h00, then B granted.
REQ-036 A: set 5, B: clear 5 simultaneously, pointer at B -> B clear first (r=8'h20), then A set (s=8'h20); shadow[5]=1; s&r=0 every cycle.
REQ-037 With N=6: req_a idx=7 -> gnt_a=1, err=1, s=r=0, shadow unchanged.
REQ-038 rst=0 asserted in ISSUE cycle -> next cycle s=r=0, gnt=0, shadow=0, state IDLE.
